// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole round controller.
package whack_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    PLAY   = 3'd2,
    PAUSED = 3'd3,
    OVER   = 3'd4
  } state_t;

  localparam int unsigned SCORE_W = 4;
  localparam int unsigned LIFE_W  = 4;
  localparam int unsigned LFSR_W  = 8;

  localparam logic [SCORE_W-1:0] SCORE_MAX = 4'd15;

  // x^8+x^6+x^5+x^4+1 as feedback taps on a left-shifting register
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/mole_lfsr.sv
// Free-running LFSR folded into a hole index that never repeats the previous hole.
module mole_lfsr
  import whack_pkg::*;
#(
  parameter int unsigned NUM_HOLES = 9,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hA5,
  localparam int unsigned HOLE_W = $clog2(NUM_HOLES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HOLE_W-1:0] prev_pos,
  output logic [HOLE_W-1:0] next_pos
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [HOLE_W-1:0] cand;
  logic [HOLE_W-1:0] folded;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  // One conditional subtract suffices since the raw candidate is below 2*NUM_HOLES
  always_comb begin
    cand   = lfsr_q[HOLE_W-1:0];
    folded = cand;
    if ({1'b0, cand} >= (HOLE_W+1)'(NUM_HOLES)) begin
      folded = cand - HOLE_W'(NUM_HOLES);
    end
    next_pos = folded;
    if (folded == prev_pos) begin
      next_pos = (folded == HOLE_W'(NUM_HOLES - 1)) ? '0 : folded + HOLE_W'(1);
    end
  end

endmodule

// File: rtl/whack_game_ctrl.sv
// Round sequencer: timer control, mole spawn/retire, hit judging and score.
// Optional WHACK_MISS_PENALTY_EN: wrong hits during play cost one point.
module whack_game_ctrl
  import whack_pkg::*;
#(
  parameter int unsigned NUM_HOLES  = 9,
  parameter int unsigned MOLE_TICKS = 2,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hA5,
  localparam int unsigned HOLE_W = $clog2(NUM_HOLES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_pulse,
  input  logic                 pause_pulse,
  input  logic [NUM_HOLES-1:0] hit,
  input  logic                 tick,
  input  logic                 timer_done,
  output logic                 timer_rst,
  output logic                 timer_enable,
  output logic                 timer_pause,
  output logic [HOLE_W-1:0]    mole_pos,
  output logic                 mole_valid,
  output logic [SCORE_W-1:0]   score,
  output logic                 hit_ack,
  output logic                 game_over
);

  state_t             state_q, state_d;
  logic [LIFE_W-1:0]  life_q, life_d;
  logic [HOLE_W-1:0]  spawn_pos;
  logic               correct_hit;

  logic               timer_rst_d, timer_enable_d, timer_pause_d, game_over_d;
  logic               mole_valid_d, hit_ack_d;
  logic [HOLE_W-1:0]  mole_pos_d;
  logic [SCORE_W-1:0] score_d;

  mole_lfsr #(
    .NUM_HOLES (NUM_HOLES),
    .LFSR_SEED (LFSR_SEED)
  ) u_mole_lfsr (
    .clk      (clk),
    .rst      (rst),
    .prev_pos (mole_pos),
    .next_pos (spawn_pos)
  );

  assign correct_hit = mole_valid && ((hit & (NUM_HOLES'(1) << mole_pos)) != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      life_q       <= '0;
      timer_rst    <= 1'b0;
      timer_enable <= 1'b0;
      timer_pause  <= 1'b0;
      mole_pos     <= '0;
      mole_valid   <= 1'b0;
      score        <= '0;
      hit_ack      <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state_q      <= state_d;
      life_q       <= life_d;
      timer_rst    <= timer_rst_d;
      timer_enable <= timer_enable_d;
      timer_pause  <= timer_pause_d;
      mole_pos     <= mole_pos_d;
      mole_valid   <= mole_valid_d;
      score        <= score_d;
      hit_ack      <= hit_ack_d;
      game_over    <= game_over_d;
    end
  end

  // Timer/status outputs follow the state being entered so they land one cycle after the event
  always_comb begin
    state_d      = state_q;
    life_d       = life_q;
    mole_pos_d   = mole_pos;
    mole_valid_d = mole_valid;
    score_d      = score;
    hit_ack_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_pulse) begin
          state_d      = START;
          score_d      = '0;
          mole_valid_d = 1'b0;
        end
      end
      START: begin
        state_d = PLAY;
      end
      PLAY: begin
        if (timer_done) begin
          state_d      = OVER;
          mole_valid_d = 1'b0;
        end else if (pause_pulse) begin
          state_d = PAUSED;
        end else if (correct_hit) begin
          score_d      = (score == SCORE_MAX) ? score : score + SCORE_W'(1);
          mole_valid_d = 1'b0;
          hit_ack_d    = 1'b1;
        end else begin
`ifdef WHACK_MISS_PENALTY_EN
          if ((hit != '0) && (score != '0)) begin
            score_d = score - SCORE_W'(1);
          end
`endif
          if (tick) begin
            if (mole_valid) begin
              life_d = life_q - LIFE_W'(1);
              if (life_q == LIFE_W'(1)) begin
                mole_valid_d = 1'b0;
              end
            end else begin
              mole_valid_d = 1'b1;
              mole_pos_d   = spawn_pos;
              life_d       = LIFE_W'(MOLE_TICKS);
            end
          end
        end
      end
      PAUSED: begin
        if (timer_done) begin
          state_d      = OVER;
          mole_valid_d = 1'b0;
        end else if (pause_pulse) begin
          state_d = PLAY;
        end
      end
      OVER: begin
        mole_valid_d = 1'b0;
        if (start_pulse) begin
          state_d = START;
          score_d = '0;
        end
      end
      default: begin
        state_d      = IDLE;
        mole_valid_d = 1'b0;
      end
    endcase

    timer_rst_d    = (state_d == START);
    timer_enable_d = (state_d == PLAY) || (state_d == PAUSED);
    timer_pause_d  = (state_d == PAUSED);
    game_over_d    = (state_d == OVER);
  end

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Directed bench for whack_game_ctrl with a rule-level reference model checked every cycle.
module tb_whack_game_ctrl;

  localparam int N          = 9;
  localparam int HW         = $clog2(N);
  localparam int LIFE_TICKS = 2;
  localparam int SEED       = 'hA5;

  localparam int P_IDLE = 0, P_START = 1, P_PLAY = 2, P_PAUSED = 3, P_OVER = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start_pulse = 1'b0;
  logic         pause_pulse = 1'b0;
  logic [N-1:0] hit = '0;
  logic         tick = 1'b0;
  logic         timer_done = 1'b0;
  logic         timer_rst, timer_enable, timer_pause, mole_valid, hit_ack, game_over;
  logic [HW-1:0] mole_pos;
  logic [3:0]   score;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  whack_game_ctrl #(
    .NUM_HOLES  (N),
    .MOLE_TICKS (LIFE_TICKS),
    .LFSR_SEED  (8'hA5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_pulse  (start_pulse),
    .pause_pulse  (pause_pulse),
    .hit          (hit),
    .tick         (tick),
    .timer_done   (timer_done),
    .timer_rst    (timer_rst),
    .timer_enable (timer_enable),
    .timer_pause  (timer_pause),
    .mole_pos     (mole_pos),
    .mole_valid   (mole_valid),
    .score        (score),
    .hit_ack      (hit_ack),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  // Reference model state
  int m_phase, m_lfsr, m_pos, m_life, m_score;
  int m_valid, m_hit_ack, m_trst, m_ten, m_tpause, m_over;

  function automatic int hole_of(int l, int prev);
    int c;
    c = l % (1 << HW);
    if (c >= N) c = c - N;
    if (c == prev) c = (c + 1) % N;
    return c;
  endfunction

  function automatic int lfsr_next(int l);
    int fb;
    fb = (((l >> 7) & 1) + ((l >> 5) & 1) + ((l >> 4) & 1) + ((l >> 3) & 1)) % 2;
    return ((l << 1) & 255) | fb;
  endfunction

  always @(posedge clk or posedge rst) begin
    int  cand;
    bit  correct, wrong;
    if (rst) begin
      m_phase = P_IDLE; m_lfsr = SEED; m_pos = 0; m_life = 0; m_score = 0;
      m_valid = 0; m_hit_ack = 0; m_trst = 0; m_ten = 0; m_tpause = 0; m_over = 0;
    end else begin
      cand      = hole_of(m_lfsr, m_pos);
      correct   = (m_valid != 0) && hit[m_pos];
      wrong     = (hit != '0) && !correct;
      m_hit_ack = 0;
      case (m_phase)
        P_IDLE:  if (start_pulse) begin m_phase = P_START; m_score = 0; m_valid = 0; end
        P_START: m_phase = P_PLAY;
        P_PLAY: begin
          if (timer_done) begin
            m_phase = P_OVER; m_valid = 0;
          end else if (pause_pulse) begin
            m_phase = P_PAUSED;
          end else if (correct) begin
            m_score   = (m_score < 15) ? m_score + 1 : 15;
            m_valid   = 0;
            m_hit_ack = 1;
          end else begin
`ifdef WHACK_MISS_PENALTY_EN
            if (wrong && m_score > 0) m_score = m_score - 1;
`endif
            if (tick) begin
              if (m_valid != 0) begin
                m_life = m_life - 1;
                if (m_life == 0) m_valid = 0;
              end else begin
                m_valid = 1; m_pos = cand; m_life = LIFE_TICKS;
              end
            end
          end
        end
        P_PAUSED: begin
          if (timer_done) begin m_phase = P_OVER; m_valid = 0; end
          else if (pause_pulse) m_phase = P_PLAY;
        end
        default: if (start_pulse) begin m_phase = P_START; m_score = 0; m_valid = 0; end
      endcase
      m_lfsr   = lfsr_next(m_lfsr);
      m_trst   = (m_phase == P_START);
      m_ten    = (m_phase == P_PLAY || m_phase == P_PAUSED);
      m_tpause = (m_phase == P_PAUSED);
      m_over   = (m_phase == P_OVER);
      if (wrong) begin end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, sampled on the falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m.timer_rst",    int'(timer_rst),    m_trst);
      check("m.timer_enable", int'(timer_enable), m_ten);
      check("m.timer_pause",  int'(timer_pause),  m_tpause);
      check("m.mole_valid",   int'(mole_valid),   m_valid);
      check("m.mole_pos",     int'(mole_pos),     m_pos);
      check("m.score",        int'(score),        m_score);
      check("m.hit_ack",      int'(hit_ack),      m_hit_ack);
      check("m.game_over",    int'(game_over),    m_over);
    end
  end

  // Apply one cycle of inputs; returns on the next falling edge with results visible
  task automatic step(input bit s, input bit p, input logic [N-1:0] h, input bit t, input bit d);
    start_pulse = s; pause_pulse = p; hit = h; tick = t; timer_done = d;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, '0, 0, 0);
  endtask

  initial begin
    int p1;
    int budget;
    logic [N-1:0] hv;

    #1 rst = 1'b1;
    @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset.score", int'(score), 0);
    check("reset.timer_enable", int'(timer_enable), 0);

    // start: timer_rst at +1, timer_enable at +2
    step(1, 0, '0, 0, 0);
    check("start.timer_rst", int'(timer_rst), 1);
    check("start.score", int'(score), 0);
    idle();
    check("start.timer_enable", int'(timer_enable), 1);
    check("start.timer_rst_low", int'(timer_rst), 0);

    // wait until the LFSR would place a mole in hole 4
    budget = 0;
    while (hole_of(m_lfsr, m_pos) != 4 && budget < 600) begin
      idle();
      budget++;
    end
    check("spawn.budget", int'(budget < 600), 1);
    step(0, 0, '0, 1, 0);
    check("spawn.mole_valid", int'(mole_valid), 1);
    check("spawn.mole_pos", int'(mole_pos), 4);

    hv = 9'b000010000;
    step(0, 0, hv, 0, 0);
    check("hit.score", int'(score), 1);
    check("hit.hit_ack", int'(hit_ack), 1);
    check("hit.mole_valid", int'(mole_valid), 0);
    idle();
    check("hit.ack_one_cycle", int'(hit_ack), 0);

    // 16 more correct hits saturate at 15
    for (int i = 0; i < 16; i++) begin
      step(0, 0, '0, 1, 0);
      hv = '0;
      hv[m_pos] = 1'b1;
      step(0, 0, hv, 0, 0);
    end
    check("sat.score", int'(score), 15);

    step(0, 0, 9'h001, 0, 0);
`ifdef WHACK_MISS_PENALTY_EN
    check("wrong.score", int'(score), 14);
`else
    check("wrong.score", int'(score), 15);
`endif

    // life: spawn, two ticks retire, next tick re-spawns elsewhere
    step(0, 0, '0, 1, 0);
    p1 = m_pos;
    check("life.spawn", int'(mole_valid), 1);
    step(0, 0, '0, 1, 0);
    check("life.tick1", int'(mole_valid), 1);
    step(0, 0, '0, 1, 0);
    check("life.tick2_retire", int'(mole_valid), 0);
    step(0, 0, '0, 1, 0);
    check("life.respawn", int'(mole_valid), 1);
    check("life.new_hole", int'(int'(mole_pos) != p1), 1);

    // pause freezes mole and score
    p1 = m_pos;
    step(0, 1, '0, 0, 0);
    check("pause.timer_pause", int'(timer_pause), 1);
    hv = '0;
    hv[p1] = 1'b1;
    step(0, 0, hv, 1, 0);
    check("pause.mole_pos", int'(mole_pos), p1);
    check("pause.mole_valid", int'(mole_valid), 1);
    check("pause.hit_ack", int'(hit_ack), 0);
    step(0, 1, '0, 0, 0);
    check("resume.timer_pause", int'(timer_pause), 0);
    check("resume.timer_enable", int'(timer_enable), 1);

    // timer_done wins over pause_pulse
    step(0, 1, '0, 0, 1);
    check("over.game_over", int'(game_over), 1);
    check("over.mole_valid", int'(mole_valid), 0);
    check("over.timer_pause", int'(timer_pause), 0);
    step(1, 0, '0, 0, 0);
    check("restart.score", int'(score), 0);
    check("restart.timer_rst", int'(timer_rst), 1);
    check("restart.game_over", int'(game_over), 0);
    idle();
    step(0, 0, 9'h001, 0, 0);
    check("restart.wrong_at_zero", int'(score), 0);

    // build a small score, then an asynchronous reset mid-round
    step(0, 0, '0, 1, 0);
    hv = '0;
    hv[m_pos] = 1'b1;
    step(0, 0, hv, 0, 0);
    check("mid.score", int'(score), 1);
    #2 rst = 1'b1;
    #1;
    check("async.score", int'(score), 0);
    check("async.timer_enable", int'(timer_enable), 0);
    check("async.mole_valid", int'(mole_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, '0, 1, 0);
    check("idle.tick_ignored", int'(mole_valid), 0);
    check("idle.timer_enable", int'(timer_enable), 0);
    idle();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
